video_timing_gen: RTL and testbench

//  Parametrised synthesizable raster timing + test-pattern source for image-pipeline blocks (gauss/avg filters).

---
 rtl/video_timing_pkg.sv | 7 +
 rtl/vtg_pattern.sv | 40 ++++
 rtl/video_timing_gen.sv | 130 +++++++++++++
 tb/tb_video_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and widths for the raster timing generator and its pattern source.
package video_timing_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {PAT_RAMP, PAT_CHECK, PAT_BARS, PAT_CONST} pat_mode_e;
  typedef enum logic {ST_IDLE, ST_RUN} vtg_state_e;
endpackage

// File: rtl/vtg_pattern.sv
// Combinational test-pattern generator: one DW-bit value per channel from the active (x,y).
module vtg_pattern
  import video_timing_pkg::*;
#(
  parameter int H_DISP   = 1280,
  parameter int DW       = 8,
  parameter int NCH      = 1,
  parameter int CHK_LOG2 = 4
) (
  input  logic [CNT_W-1:0]  x_i,
  input  logic [CNT_W-1:0]  y_i,
  input  pat_mode_e         mode_i,
  input  logic [NCH*DW-1:0] const_val_i,
  output logic [NCH*DW-1:0] data_o
);
  logic [2:0] bar;
  logic       chk_bit;

  // Eight equal-width bars across the active line.
  assign bar     = 3'(({x_i, 3'b000}) / (CNT_W+3)'(H_DISP));
  assign chk_bit = x_i[CHK_LOG2] ^ y_i[CHK_LOG2];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int BI = c % 3;
    logic [DW-1:0] ch_val;

    always_comb begin
      ch_val = '0;
      case (mode_i)
        PAT_RAMP:  ch_val = DW'(x_i) + DW'(y_i) + DW'(c << (DW-2));
        PAT_CHECK: ch_val = chk_bit ? '1 : '0;
        PAT_BARS:  ch_val = bar[BI] ? '1 : '0;
        PAT_CONST: ch_val = const_val_i[c*DW +: DW];
        default:   ch_val = '0;
      endcase
    end

    assign data_o[c*DW +: DW] = ch_val;
  end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with start/stop control, frame counting and a test-pattern data path.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int H_DISP   = 1280,
  parameter int H_FRONT  = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int V_DISP   = 720,
  parameter int V_FRONT  = 5,
  parameter int DW       = 8,
  parameter int NCH      = 1,
  parameter bit SYNC_POL = 1'b1,
  parameter int CHK_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              oneshot_i,
  input  logic [1:0]        mode_i,
  input  logic [NCH*DW-1:0] const_val_i,
  output logic              busy_o,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic              valid_o,
  output logic [NCH*DW-1:0] data_o,
  output logic [CNT_W-1:0]  x_o,
  output logic [CNT_W-1:0]  y_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] HA0 = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA1 = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VA0 = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA1 = CNT_W'(V_SYNC + V_BACK + V_DISP);

  vtg_state_e        state_q;
  logic [CNT_W-1:0]  h_q, v_q, h_d, v_d;
  logic              stop_pend_q, oneshot_q;
  pat_mode_e         mode_q;
  logic [NCH*DW-1:0] const_q;

  logic              h_last, v_last, frame_last, active;
  logic [CNT_W-1:0]  x_d, y_d;
  logic [NCH*DW-1:0] pat;

  assign h_last     = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last     = (v_q == CNT_W'(V_TOTAL - 1));
  assign frame_last = h_last && v_last;
  assign h_d        = h_last ? '0 : h_q + 1'b1;
  assign v_d        = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
  assign active     = (h_q >= HA0) && (h_q < HA1) && (v_q >= VA0) && (v_q < VA1);
  assign x_d        = active ? h_q - HA0 : '0;
  assign y_d        = active ? v_q - VA0 : '0;
  assign busy_o     = (state_q == ST_RUN);

  vtg_pattern #(.H_DISP(H_DISP), .DW(DW), .NCH(NCH), .CHK_LOG2(CHK_LOG2)) u_pat (
    .x_i(x_d), .y_i(y_d), .mode_i(mode_q), .const_val_i(const_q), .data_o(pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      stop_pend_q  <= 1'b0;
      oneshot_q    <= 1'b0;
      mode_q       <= PAT_RAMP;
      const_q      <= '0;
      vsync_o      <= ~SYNC_POL;
      hsync_o      <= ~SYNC_POL;
      valid_o      <= 1'b0;
      data_o       <= '0;
      x_o          <= '0;
      y_o          <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      vsync_o      <= ~SYNC_POL;
      hsync_o      <= ~SYNC_POL;
      valid_o      <= 1'b0;
      data_o       <= '0;
      x_o          <= '0;
      y_o          <= '0;
      frame_done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q     <= ST_RUN;
            h_q         <= '0;
            v_q         <= '0;
            mode_q      <= pat_mode_e'(mode_i);
            const_q     <= const_val_i;
            oneshot_q   <= oneshot_i;
            stop_pend_q <= stop_i;
          end
        end
        ST_RUN: begin
          vsync_o <= (v_q < CNT_W'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
          hsync_o <= (h_q < CNT_W'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
          valid_o <= active;
          data_o  <= active ? pat : '0;
          x_o     <= x_d;
          y_o     <= y_d;
          h_q     <= h_d;
          v_q     <= v_d;
          if (stop_i) stop_pend_q <= 1'b1;
          // Frame boundary: count it, latch next frame's settings, maybe retire.
          if (frame_last) begin
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 1'b1;
            mode_q       <= pat_mode_e'(mode_i);
            const_q      <= const_val_i;
            oneshot_q    <= oneshot_i;
            if (stop_pend_q || oneshot_q) begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 21x21 raster with a 15x15 active window.
module tb_video_timing_gen;
  localparam int HD = 15;
  localparam int VD = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i, oneshot_i;
  logic [1:0]  mode_i;
  logic [23:0] const_val_i;
  logic        busy_o, vsync_o, hsync_o, valid_o, frame_done_o;
  logic [23:0] data_o;
  logic [15:0] x_o, y_o, frame_cnt_o;

  video_timing_gen #(
    .H_SYNC(1), .H_BACK(2), .H_DISP(HD), .H_FRONT(3),
    .V_SYNC(1), .V_BACK(2), .V_DISP(VD), .V_FRONT(3),
    .DW(8), .NCH(3), .SYNC_POL(1'b0), .CHK_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .oneshot_i(oneshot_i),
    .mode_i(mode_i), .const_val_i(const_val_i), .busy_o(busy_o), .vsync_o(vsync_o),
    .hsync_o(hsync_o), .valid_o(valid_o), .data_o(data_o), .x_o(x_o), .y_o(y_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_valid, n_fd, n_vs, n_hs;
  logic [63:0] sb_q[$];
  logic [23:0] pix_mem [VD][HD];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int m, input int x, input int y, input logic [23:0] cv);
    logic [23:0] r;
    int b;
    r = '0;
    b = x * 8 / HD;
    for (int c = 0; c < 3; c++) begin
      case (m)
        0: r[c*8 +: 8] = 8'((x + y + c * 64) & 255);
        1: r[c*8 +: 8] = (((x >> 2) ^ (y >> 2)) & 1) != 0 ? 8'hFF : 8'h00;
        2: r[c*8 +: 8] = ((b >> (c % 3)) & 1) != 0 ? 8'hFF : 8'h00;
        default: r[c*8 +: 8] = cv[c*8 +: 8];
      endcase
    end
    return r;
  endfunction

  task automatic push_frame(input int m, input logic [23:0] cv);
    for (int y = 0; y < VD; y++)
      for (int x = 0; x < HD; x++)
        sb_q.push_back({8'h00, 16'(x), 16'(y), exp_pix(m, x, y, cv)});
  endtask

  // Monitor: every valid pixel is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        n_valid++;
        if (sb_q.size() == 0) chk("sb_underrun", 64'(sb_q.size()), 64'd1);
        else chk("pix", {8'h00, x_o, y_o, data_o}, sb_q.pop_front());
        if (x_o < HD && y_o < VD) pix_mem[y_o][x_o] = data_o;
      end
      if (frame_done_o) n_fd++;
      if (!vsync_o) n_vs++;
      if (!hsync_o) n_hs++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start_i = 0; stop_i = 0; oneshot_i = 0; mode_i = 0; const_val_i = 0;
    sb_q.delete();
    n_valid = 0; n_fd = 0; n_vs = 0; n_hs = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic os, input logic [1:0] m, input logic [23:0] cv);
    @(negedge clk);
    start_i = 1'b1; oneshot_i = os; mode_i = m; const_val_i = cv;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy_o && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(busy_o), 64'd0);
  endtask

  task automatic wait_fd(input int k, input int max);
    int n = 0;
    while (n_fd < k && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("fd_reached", 64'(n_fd >= k), 64'd1);
  endtask

  initial begin
    int n, vs1, vs2, v0;
    rst = 1'b1;
    start_i = 0; stop_i = 0; oneshot_i = 0; mode_i = 0; const_val_i = 0;
    n_valid = 0; n_fd = 0; n_vs = 0; n_hs = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_syncs", {62'd0, vsync_o, hsync_o}, 64'd3);
    chk("rst_data", 64'(data_o), 0);
    chk("rst_fcnt", 64'(frame_cnt_o), 0);
    chk("rst_fdone", 64'(frame_done_o), 0);

    // One-shot ramp frame: exact busy length and sync latency.
    do_reset();
    push_frame(0, 24'h0);
    @(negedge clk);
    start_i = 1'b1; oneshot_i = 1'b1; mode_i = 2'd0;
    n = 0; vs1 = 0; vs2 = 0;
    do begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o) n++;
      if (n == 1) vs1 = vsync_o;
      if (n == 2) vs2 = vsync_o;
    end while (busy_o && n < 1000);
    chk("busy_clks", 64'(n), 64'd441);
    chk("vs_before", 64'(vs1), 64'd1);
    chk("vs_first", 64'(vs2), 64'd0);
    @(negedge clk);
    chk("os_fcnt", 64'(frame_cnt_o), 64'd1);
    chk("os_fd", 64'(n_fd), 64'd1);
    chk("os_nvalid", 64'(n_valid), 64'd225);
    chk("os_sb_empty", 64'(sb_q.size()), 0);
    chk("ramp_x3y2", 64'(pix_mem[2][3]), 64'h854505);

    // Continuous run, stop mid frame 2.
    do_reset();
    push_frame(0, 24'h0);
    push_frame(0, 24'h0);
    pulse_start(1'b0, 2'd0, 24'h0);
    wait_fd(1, 2000);
    repeat (100) @(negedge clk);
    pulse_stop();
    wait_idle(1000);
    @(negedge clk);
    chk("stop_fcnt", 64'(frame_cnt_o), 64'd2);
    chk("stop_nvalid", 64'(n_valid), 64'd450);
    chk("stop_sb_empty", 64'(sb_q.size()), 0);
    v0 = n_valid;
    repeat (60) @(negedge clk);
    chk("stop_no_more", 64'(n_valid), 64'(v0));
    chk("stop_fd", 64'(n_fd), 64'd2);

    // Colour bars and sync widths.
    do_reset();
    push_frame(2, 24'h0);
    pulse_start(1'b1, 2'd2, 24'h0);
    wait_idle(1000);
    @(negedge clk);
    chk("hs_clks", 64'(n_hs), 64'd21);
    chk("vs_clks", 64'(n_vs), 64'd21);
    chk("bar_x0", 64'(pix_mem[0][0]), 64'h000000);
    chk("bar_x1", 64'(pix_mem[7][1]), 64'h000000);
    chk("bar_x14", 64'(pix_mem[5][14]), 64'hFFFFFF);
    chk("bars_sb_empty", 64'(sb_q.size()), 0);

    // Constant mode; mid-frame change only lands on the next frame.
    do_reset();
    push_frame(3, 24'h123456);
    push_frame(3, 24'hABCDEF);
    pulse_start(1'b0, 2'd3, 24'h123456);
    repeat (150) @(negedge clk);
    const_val_i = 24'hABCDEF;
    wait_fd(1, 2000);
    repeat (10) @(negedge clk);
    pulse_stop();
    wait_idle(1000);
    @(negedge clk);
    chk("const_fd", 64'(n_fd), 64'd2);
    chk("const_sb_empty", 64'(sb_q.size()), 0);
    chk("const_f2", 64'(pix_mem[0][0]), 64'hABCDEF);

    // Asynchronous reset mid-line, then a clean frame.
    do_reset();
    push_frame(0, 24'h0);
    push_frame(0, 24'h0);
    push_frame(0, 24'h0);
    pulse_start(1'b0, 2'd0, 24'h0);
    wait_fd(1, 2000);
    repeat (130) @(negedge clk);
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    #2;
    sb_q.delete();
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 0);
    chk("arst_busy", 64'(busy_o), 0);
    chk("arst_syncs", {62'd0, vsync_o, hsync_o}, 64'd3);
    chk("arst_fcnt", 64'(frame_cnt_o), 0);
    do_reset();
    push_frame(0, 24'h0);
    pulse_start(1'b1, 2'd0, 24'h0);
    wait_idle(1000);
    @(negedge clk);
    chk("clean_nvalid", 64'(n_valid), 64'd225);
    chk("clean_fcnt", 64'(frame_cnt_o), 64'd1);
    chk("clean_sb_empty", 64'(sb_q.size()), 0);

    // Frame counter wrap, checker pattern.
    do_reset();
    force dut.frame_cnt_o = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_o;
    @(negedge clk);
    chk("wrap_preset", 64'(frame_cnt_o), 64'hFFFF);
    push_frame(1, 24'h0);
    pulse_start(1'b1, 2'd1, 24'h0);
    wait_idle(1000);
    @(negedge clk);
    chk("wrap_fcnt", 64'(frame_cnt_o), 64'h0000);
    chk("wrap_fd", 64'(n_fd), 64'd1);
    chk("chk_sb_empty", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
